dt_res_scan: RTL

Post-processing stage downstream of the distance-transform engine. After the engine reports done, this block sweeps the 128×128 result RAM once in raster order. It reports the peak distance value, the lowest address holding that peak, and the count of object (non-zero) pixels, with an optional sum of all distances. It shares the result RAM's read port and must not be started while the engine is writing.

---
 rtl/dt_res_scan.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dt_res_scan.sv
// dt_res_scan: single raster sweep over the distance-transform result RAM.
// Reports the peak distance, the lowest address holding it and the number of
// non-zero pixels.
// Optional feature macro: SUM_EN builds the dist_sum port and accumulator.
module dt_res_scan #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 15,
    parameter int SUM_W  = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              res_rd,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [DATA_W-1:0] res_di,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_addr,
    output logic [CNT_W-1:0]  obj_cnt
`ifdef SUM_EN
    ,
    output logic [SUM_W-1:0]  dist_sum
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg;
    state_t            state_next;
    logic              res_rd_reg;
    logic [ADDR_W-1:0] res_addr_reg;
    logic [DATA_W-1:0] max_val_reg;
    logic [ADDR_W-1:0] max_addr_reg;
    logic [CNT_W-1:0]  obj_cnt_reg;

    // The RAM samples the address on the falling edge, so the data arriving
    // at a rising edge belongs to the address still held in res_addr_reg;
    // that register therefore acts as the one-cycle-delayed capture address.
    logic [ADDR_W-1:0] cap_addr;
    assign cap_addr = res_addr_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                // The pixel captured on this edge is the last one.
                if (res_addr_reg == LAST_ADDR) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address sequencer and peak/count capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_rd_reg   <= 1'b0;
            res_addr_reg <= '0;
            max_val_reg  <= '0;
            max_addr_reg <= '0;
            obj_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        res_rd_reg   <= 1'b1;
                        res_addr_reg <= '0;
                        max_val_reg  <= '0;
                        max_addr_reg <= '0;
                        obj_cnt_reg  <= '0;
                    end
                end
                READ: begin
                    // Strict compare keeps the earliest address on ties.
                    if (res_di > max_val_reg) begin
                        max_val_reg  <= res_di;
                        max_addr_reg <= cap_addr;
                    end
                    if (res_di != '0) begin
                        obj_cnt_reg <= obj_cnt_reg + CNT_W'(1);
                    end
                    // Stop reading at the last address; never wrap.
                    if (res_addr_reg == LAST_ADDR) begin
                        res_rd_reg <= 1'b0;
                    end else begin
                        res_addr_reg <= res_addr_reg + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUM_EN
    logic [SUM_W-1:0] dist_sum_reg;

    // Distance accumulator, cleared on start and fed every capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_sum_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            dist_sum_reg <= '0;
        end else if (state_reg == READ) begin
            dist_sum_reg <= dist_sum_reg + {{(SUM_W-DATA_W){1'b0}}, res_di};
        end
    end

    assign dist_sum = dist_sum_reg;
`endif

    assign res_rd   = res_rd_reg;
    assign res_addr = res_addr_reg;
    assign max_val  = max_val_reg;
    assign max_addr = max_addr_reg;
    assign obj_cnt  = obj_cnt_reg;

endmodule
